// File: rtl/rns_conv_scheduler.sv
// Round-robin scheduler that shares one registered binary-to-RNS converter among NREQ
// requesters, range-checks each operand, and returns tagged results in issue order through a
// first-word-fall-through FIFO. Credits bound in-flight plus buffered results to FIFO_DEPTH.
module rns_conv_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned CONV_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        conv_n,
  input  logic [2:0]         conv_mod_1,
  input  logic [2:0]         conv_mod_2,
  input  logic [2:0]         conv_mod_3,
  input  logic [2:0]         conv_mod_4,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_err,
  output logic [2:0]         res_mod_1,
  output logic [2:0]         res_mod_2,
  output logic [2:0]         res_mod_3,
  output logic [2:0]         res_mod_4
);

  localparam int unsigned PipeD = CONV_LAT + 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [31:0] RangeLo = -32'sd420;
  localparam logic signed [31:0] RangeHi = 32'sd419;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             err;
  } pipe_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [11:0]      mods;
  } entry_t;

  logic [TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]         credits_q, credits_d;
  logic [31:0]             conv_n_q;
  pipe_t [PipeD-1:0]       pipe_q, pipe_d;
  entry_t                  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;

  logic                    issue;
  logic [TAG_W-1:0]        grant_idx;
  logic signed [31:0]      sel_n;
  logic                    sel_err;
  logic                    wr_en;
  entry_t                  wr_entry;
  entry_t                  head;
  logic                    pop;

  // Round-robin grant: first valid at or after rr_ptr, else first valid from index 0.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    sel_n     = '0;
    issue     = 1'b0;
    if (!reset && (credits_q != '0)) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!issue && req_valid[i] && (i >= int'(rr_ptr_q))) begin
          issue        = 1'b1;
          req_ready[i] = 1'b1;
          grant_idx    = TAG_W'(i);
          sel_n        = req_data[32*i +: 32];
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!issue && req_valid[i]) begin
          issue        = 1'b1;
          req_ready[i] = 1'b1;
          grant_idx    = TAG_W'(i);
          sel_n        = req_data[32*i +: 32];
        end
      end
    end
  end

  // Range check, pointer/credit next state and tag pipe shift.
  always_comb begin
    sel_err   = (sel_n < RangeLo) || (sel_n > RangeHi);
    rr_ptr_d  = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    pop       = res_valid && res_ready;
    credits_d = credits_q - CntW'(issue) + CntW'(pop);
    pipe_d[0] = '{valid: issue, tag: grant_idx, err: sel_err};
    for (int k = 1; k < int'(PipeD); k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // Result capture: out-of-range operands store zero residues.
  always_comb begin
    wr_en         = pipe_q[PipeD-1].valid;
    wr_entry.tag  = pipe_q[PipeD-1].tag;
    wr_entry.err  = pipe_q[PipeD-1].err;
    wr_entry.mods = pipe_q[PipeD-1].err ? 12'd0
                                        : {conv_mod_1, conv_mod_2, conv_mod_3, conv_mod_4};
  end

  // Arbiter pointer, credits, converter operand and tag pipe state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      credits_q <= CntW'(FIFO_DEPTH);
      conv_n_q  <= '0;
      pipe_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      pipe_q    <= pipe_d;
      if (issue) begin
        conv_n_q <= sel_n;
      end
    end
  end

  // Result FIFO storage and pointers; credits guarantee a write never finds it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < int'(FIFO_DEPTH); e++) begin
        mem_q[e] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(wr_en) - CntW'(pop);
    end
  end

  // Head of FIFO drives the result port directly.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    res_valid = (count_q != '0);
    res_tag   = head.tag;
    res_err   = head.err;
    res_mod_1 = head.mods[11:9];
    res_mod_2 = head.mods[8:6];
    res_mod_3 = head.mods[5:3];
    res_mod_4 = head.mods[2:0];
    conv_n    = conv_n_q;
  end

endmodule

// File: tb/tb_rns_conv_scheduler.sv
// Self-checking bench: behavioural converter (moduli 8,7,5,3), queue-based reference model of
// arbitration, credits, latency and ordering, plus table-driven directed sequences.
`timescale 1ns/100ps
module tb_rns_conv_scheduler;

  localparam int NREQ       = 4;
  localparam int TAG_W      = 2;
  localparam int CONV_LAT   = 1;
  localparam int FIFO_DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        conv_n;
  logic [2:0]         conv_mod_1, conv_mod_2, conv_mod_3, conv_mod_4;
  logic               res_valid;
  logic               res_ready;
  logic [TAG_W-1:0]   res_tag;
  logic               res_err;
  logic [2:0]         res_mod_1, res_mod_2, res_mod_3, res_mod_4;

  rns_conv_scheduler #(
    .NREQ(NREQ), .TAG_W(TAG_W), .CONV_LAT(CONV_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .conv_n(conv_n), .conv_mod_1(conv_mod_1),
    .conv_mod_2(conv_mod_2), .conv_mod_3(conv_mod_3), .conv_mod_4(conv_mod_4),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_err(res_err),
    .res_mod_1(res_mod_1), .res_mod_2(res_mod_2), .res_mod_3(res_mod_3), .res_mod_4(res_mod_4)
  );

  always #5 clk = ~clk;

  // Reference converter: residues mod 8, 7, 5, 3 of the signed operand.
  function automatic logic [11:0] conv_f(input logic [31:0] x);
    int n, a, b, c, d;
    n = int'($signed(x));
    a = n % 8; if (a < 0) a += 8;
    b = n % 7; if (b < 0) b += 7;
    c = n % 5; if (c < 0) c += 5;
    d = n % 3; if (d < 0) d += 3;
    return {a[2:0], b[2:0], c[2:0], d[2:0]};
  endfunction

  // Converter pipe with CONV_LAT register stages, never reset.
  logic [31:0] cpipe [CONV_LAT];
  always @(posedge clk) begin
    cpipe[0] <= conv_n;
    for (int i = 1; i < CONV_LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign {conv_mod_1, conv_mod_2, conv_mod_3, conv_mod_4} = conv_f(cpipe[CONV_LAT-1]);

  typedef struct {
    int          tag;
    bit          err;
    logic [11:0] mods;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  int          m_rr;
  int          cyc;
  int          vecs;
  int          miscompares;
  int          last_grant;
  bit          popped;
  int          pop_tag;
  bit          pop_err;
  logic [11:0] pop_mods;
  int          npops;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: predict outputs from the model, compare, then advance the model.
  task automatic cycle();
    logic [NREQ-1:0]  er;
    logic [TAG_W-1:0] et;
    int               g;
    bit               ev;
    logic [31:0]      n;
    exp_t             e;
    #1;
    er = '0;
    g  = -1;
    if (reset) begin
      q.delete();
      m_rr = 0;
    end else if (q.size() < FIFO_DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    ev = !reset && (q.size() > 0) && (q[0].rdy <= cyc);
    chk("res_valid", res_valid, ev);
    popped = 1'b0;
    if (ev) begin
      et = TAG_W'(q[0].tag);
      chk("res_payload", {res_tag, res_err, res_mod_1, res_mod_2, res_mod_3, res_mod_4},
          {et, q[0].err, q[0].mods});
      if (res_ready) begin
        popped   = 1'b1;
        pop_tag  = int'(res_tag);
        pop_err  = res_err;
        pop_mods = {res_mod_1, res_mod_2, res_mod_3, res_mod_4};
        npops++;
        void'(q.pop_front());
      end
    end
    last_grant = g;
    if (g >= 0) begin
      n      = req_data[32*g +: 32];
      e.tag  = g;
      e.err  = ($signed(n) < -420) || ($signed(n) > 419);
      e.mods = e.err ? 12'd0 : conv_f(n);
      e.rdy  = cyc + CONV_LAT + 2;
      q.push_back(e);
      m_rr = (g + 1) % NREQ;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic signed [31:0] n;
    bit                 err;
  } rng_vec_t;

  rng_vec_t t3[4];
  int       t2_grant[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, cnt, base, n5, guard;
    vecs = 0; miscompares = 0; cyc = 0; m_rr = 0; npops = 0;

    t3[0] = '{-32'sd420, 1'b0};
    t3[1] = '{32'sd419, 1'b0};
    t3[2] = '{-32'sd421, 1'b1};
    t3[3] = '{32'sd420, 1'b1};
    t2_grant = '{0, 1, 2, 3, 0};

    // 1: reset state, then a single operand -1 from requester 0.
    reset     = 1'b1;
    res_ready = 1'b1;
    req_data  = '0;
    req_data[31:0] = 32'hFFFF_FFFF;
    req_valid = 4'b0001;
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_fields", {res_tag, res_err, res_mod_1, res_mod_2, res_mod_3, res_mod_4}, '0);
    chk("rst_conv_n", conv_n, 32'd0);
    chk("rst_credits", dut.credits_q, FIFO_DEPTH);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("t1_grant", last_grant, 0);
    req_valid = '0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (popped) begin
        got = 1;
        chk("t1_latency", i + 1, CONV_LAT + 2);
        chk("t1_result", {pop_tag[TAG_W-1:0], pop_err, pop_mods}, {2'd0, 1'b0, conv_f(-1)});
      end
    end
    chk("t1_seen", got, 1);

    // 2: all requesters valid, consumer always ready.
    do_reset();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'(i * 13 - 7);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_grant", last_grant, t2_grant[i]);
    end
    drain(10);

    // 3: range boundaries through requester 1.
    for (int v = 0; v < 4; v++) begin
      req_valid = 4'b0010;
      req_data[63:32] = t3[v].n;
      cycle();
      chk("t3_grant", last_grant, 1);
      req_valid = '0;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        cycle();
        if (popped) begin
          got = 1;
          chk("t3_err", pop_err, t3[v].err);
          chk("t3_mods", pop_mods, t3[v].err ? 12'd0 : conv_f(t3[v].n));
        end
      end
      chk("t3_seen", got, 1);
    end

    // 4: consumer stalled: exactly FIFO_DEPTH transfers, then resume on release.
    do_reset();
    req_valid = '1;
    res_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_grant >= 0) cnt++;
    end
    chk("t4_stall_count", cnt, FIFO_DEPTH);
    #1;
    chk("t4_no_grant", req_ready, 4'b0000);
    @(negedge clk);
    cyc++;
    res_ready = 1'b1;
    cnt  = 0;
    base = npops;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_grant >= 0) cnt++;
    end
    chk("t4_resume", cnt > 0, 1'b1);
    chk("t4_pops", npops - base >= FIFO_DEPTH, 1'b1);
    drain(10);

    // 5: sweep the full dynamic range through requester 2 with a random consumer.
    n5 = -420;
    base = npops;
    guard = 0;
    while (n5 <= 419 && guard < 20000) begin
      req_valid = 4'b0100;
      req_data[95:64] = 32'(n5);
      res_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (last_grant == 2) n5++;
      guard++;
    end
    chk("t5_sweep_done", n5, 420);
    drain(20);
    chk("t5_pop_total", npops - base, 840);
    chk("t5_model_empty", q.size(), 0);

    // Random traffic on all requesters with a random consumer.
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) != 0) req_data[32*r +: 32] = 32'(int'($urandom_range(0, 839)) - 420);
        else req_data[32*r +: 32] = $urandom;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(20);

    // 6: asynchronous reset with operations in flight.
    do_reset();
    req_valid = '1;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    #1;
    chk("t6_res_valid", res_valid, 1'b0);
    chk("t6_credits", dut.credits_q, FIFO_DEPTH);
    q.delete();
    m_rr = 0;
    @(negedge clk);
    cyc++;
    req_valid = '0;
    cycle();
    reset = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
